// File: rtl/gdsp_pkg.sv
// Shared DSP definitions: sample format, 16-QAM levels, decision threshold and
// the Gray mapping used by both the 16-QAM mapper and demapper.
package gdsp_pkg;

  localparam int DATA_WIDTH = 12;
  localparam int ERR_WIDTH  = DATA_WIDTH + 1;

  typedef logic signed [DATA_WIDTH-1:0] sample_t;
  typedef logic [3:0]                   qam_bits_t;
  typedef logic [1:0]                   gray_t;

  localparam sample_t QAM_THR  = 12'sd1296;
  localparam sample_t QAM_LVL1 = 12'sd648;
  localparam sample_t QAM_LVL3 = 12'sd1943;

  localparam gray_t GRAY_NEG3 = 2'b00;
  localparam gray_t GRAY_NEG1 = 2'b01;
  localparam gray_t GRAY_POS1 = 2'b11;
  localparam gray_t GRAY_POS3 = 2'b10;

  typedef enum logic [1:0] {
    LVL_NEG3,
    LVL_NEG1,
    LVL_POS1,
    LVL_POS3
  } qam_level_e;

  function automatic gray_t level_to_gray(input qam_level_e lvl);
    case (lvl)
      LVL_NEG3: level_to_gray = GRAY_NEG3;
      LVL_NEG1: level_to_gray = GRAY_NEG1;
      LVL_POS1: level_to_gray = GRAY_POS1;
      default:  level_to_gray = GRAY_POS3;
    endcase
  endfunction

  function automatic sample_t level_to_ideal(input qam_level_e lvl);
    case (lvl)
      LVL_NEG3: level_to_ideal = -QAM_LVL3;
      LVL_NEG1: level_to_ideal = -QAM_LVL1;
      LVL_POS1: level_to_ideal = QAM_LVL1;
      default:  level_to_ideal = QAM_LVL3;
    endcase
  endfunction

endpackage

// File: rtl/qam16_slicer_axis.sv
// Single-axis 16-QAM hard slicer: nearest level, its Gray code, and the
// absolute distance from the sample to that level.
module qam16_slicer_axis
  import gdsp_pkg::*;
(
  input  sample_t                x,
  output gray_t                  code,
  output sample_t                ideal,
  output logic [ERR_WIDTH-1:0]   abs_err
);

  qam_level_e                  lvl;
  logic signed [ERR_WIDTH-1:0] diff;

  // Zero falls into the +1 region, so the sign bit alone splits the inner pair.
  always_comb begin
    lvl = LVL_NEG3;
    if (x >= QAM_THR)
      lvl = LVL_POS3;
    else if (!x[DATA_WIDTH-1])
      lvl = LVL_POS1;
    else if (x > -QAM_THR)
      lvl = LVL_NEG1;
    else
      lvl = LVL_NEG3;
  end

  assign code  = level_to_gray(lvl);
  assign ideal = level_to_ideal(lvl);

  // One extra bit keeps the worst-case difference from wrapping.
  assign diff    = {x[DATA_WIDTH-1], x} - {ideal[DATA_WIDTH-1], ideal};
  assign abs_err = diff[ERR_WIDTH-1] ? -diff : diff;

endmodule

// File: rtl/qam16_demapper.sv
// 16-QAM receive demapper: symbol-phase decimation, hard slicing with Gray
// decode into a 2-entry output FIFO, and a windowed L1 error sum.
module qam16_demapper
  import gdsp_pkg::*;
#(
  parameter int SPS        = 4,
  parameter int EVM_LOG2   = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sync_clr,
  input  logic [$clog2(SPS)-1:0]   phase_sel,
  input  logic                     s_valid,
  input  sample_t                  s_i,
  input  sample_t                  s_q,
  output logic                     m_valid,
  input  logic                     m_ready,
  output qam_bits_t                m_bits,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic [14+EVM_LOG2-1:0]   evm_acc,
  output logic                     evm_valid
);

  localparam int PHASE_W = $clog2(SPS);
  localparam int E_W     = ERR_WIDTH + 1;
  localparam int ACC_W   = 14 + EVM_LOG2;

  logic [PHASE_W-1:0]   phase_cnt;
  logic                 decide;

  gray_t                code_i, code_q;
  sample_t              ideal_i, ideal_q;
  logic [ERR_WIDTH-1:0] err_i, err_q;
  logic [E_W-1:0]       err_sum;
  logic                 unused_ideal;

  qam_bits_t            mem [FIFO_DEPTH];
  logic                 rd_ptr, wr_ptr;
  logic [1:0]           count;
  logic                 full, pop, push, drop;

  logic [EVM_LOG2-1:0]  win_cnt;
  logic [ACC_W-1:0]     run_sum;
  logic [ACC_W-1:0]     err_ext;

  qam16_slicer_axis u_slice_i (
    .x       (s_i),
    .code    (code_i),
    .ideal   (ideal_i),
    .abs_err (err_i)
  );

  qam16_slicer_axis u_slice_q (
    .x       (s_q),
    .code    (code_q),
    .ideal   (ideal_q),
    .abs_err (err_q)
  );

  // The reconstructed levels are only needed by the slicer's error path here.
  assign unused_ideal = ^{ideal_i, ideal_q};

  assign decide  = s_valid && (phase_cnt == phase_sel);
  assign err_sum = {1'b0, err_i} + {1'b0, err_q};
  assign err_ext = ACC_W'(err_sum);

  // Sample index within the symbol; sync_clr realigns it to the symbol start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      phase_cnt <= '0;
    else if (sync_clr)
      phase_cnt <= '0;
    else if (s_valid)
      phase_cnt <= phase_cnt + 1'b1;
  end

  assign m_valid = (count != 2'd0);
  assign m_bits  = mem[rd_ptr];
  assign full    = (count == 2'(FIFO_DEPTH));
  assign pop     = m_valid && m_ready;
  assign push    = decide && (!full || pop);
  assign drop    = decide && full && !pop;

  // When full, a same-cycle pop frees the head slot, which is exactly wr_ptr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < FIFO_DEPTH; k++)
        mem[k] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {code_i, code_q};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overflow <= 1'b0;
    else if (drop)
      overflow <= 1'b1;
    else if (ovf_clr)
      overflow <= 1'b0;
  end

  // Dropped symbols still contribute to the error window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt   <= '0;
      run_sum   <= '0;
      evm_acc   <= '0;
      evm_valid <= 1'b0;
    end else begin
      evm_valid <= 1'b0;
      if (decide) begin
        win_cnt <= win_cnt + 1'b1;
        if (&win_cnt) begin
          evm_acc   <= run_sum + err_ext;
          evm_valid <= 1'b1;
          run_sum   <= '0;
        end else begin
          run_sum <= run_sum + err_ext;
        end
      end
    end
  end

endmodule

// File: tb/tb_qam16_demapper.sv
// Self-checking bench for qam16_demapper: slicer table, phase selection, FIFO
// full/overflow corners, EVM windows and mid-operation reset.
module tb_qam16_demapper;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                sync_clr;
  logic [1:0]          phase_sel;
  logic                s_valid;
  logic signed [11:0]  s_i, s_q;
  logic                m_valid;
  logic                m_ready;
  logic [3:0]          m_bits;
  logic                overflow;
  logic                ovf_clr;
  logic [15:0]         evm_acc;
  logic                evm_valid;

  int errors = 0;
  int checks = 0;
  int pop_count = 0;
  int evm_pulses = 0;
  int last_acc = 0;
  int pops_before;
  logic [3:0] exp_q[$];

  typedef struct {
    logic signed [11:0] i;
    logic signed [11:0] q;
    logic [3:0]         bits;
  } vec_t;
  vec_t vecs[9];

  qam16_demapper #(.SPS(4), .EVM_LOG2(2), .FIFO_DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sync_clr  (sync_clr),
    .phase_sel (phase_sel),
    .s_valid   (s_valid),
    .s_i       (s_i),
    .s_q       (s_q),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_bits    (m_bits),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .evm_acc   (evm_acc),
    .evm_valid (evm_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One symbol of SPS samples; only the selected phase carries (i,q).
  task automatic applyStimulus(input logic signed [11:0] i, input logic signed [11:0] q,
                               input logic [3:0] bits, input logic expect_out,
                               input logic ready_on_dec);
    for (int k = 0; k < 4; k++) begin
      s_valid = 1'b1;
      if (k == int'(phase_sel)) begin
        s_i = i;
        s_q = q;
        if (expect_out) exp_q.push_back(bits);
        if (ready_on_dec) m_ready = 1'b1;
      end else begin
        s_i = '0;
        s_q = '0;
      end
      step();
    end
  endtask

  task automatic syncPhase();
    s_valid  = 1'b0;
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) step();
  endtask

  // Scoreboard: every accepted pop must match the oldest expected symbol.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pop actual=%0h expected=none", m_bits);
      end else begin
        checkOutput("m_bits", {28'd0, m_bits}, {28'd0, exp_q.pop_front()});
        pop_count++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && evm_valid) begin
      evm_pulses++;
      last_acc = int'(evm_acc);
    end
  end

  initial begin
    vecs[0] = '{12'sd1295,  12'sd0,     4'b1111};
    vecs[1] = '{12'sd1296,  12'sd0,     4'b1011};
    vecs[2] = '{-12'sd1295, 12'sd0,     4'b0111};
    vecs[3] = '{-12'sd1296, 12'sd0,     4'b0011};
    vecs[4] = '{12'sd0,     12'sd0,     4'b1111};
    vecs[5] = '{12'sd0,     12'sd1296,  4'b1110};
    vecs[6] = '{12'sd0,     -12'sd1296, 4'b1100};
    vecs[7] = '{12'sd0,     -12'sd1,    4'b1101};
    vecs[8] = '{12'sd2047,  -12'sd2048, 4'b1000};

    rst_n = 1'b0; sync_clr = 1'b0; phase_sel = 2'd2; s_valid = 1'b0;
    s_i = '0; s_q = '0; m_ready = 1'b1; ovf_clr = 1'b0;
    repeat (2) step();
    checkOutput("rst_m_valid", {31'd0, m_valid}, 0);
    checkOutput("rst_m_bits", {28'd0, m_bits}, 0);
    checkOutput("rst_overflow", {31'd0, overflow}, 0);
    checkOutput("rst_evm_acc", {16'd0, evm_acc}, 0);
    checkOutput("rst_evm_valid", {31'd0, evm_valid}, 0);
    rst_n = 1'b1;
    step();

    // EVM windows of 4 decisions: 4*20 then a fresh window of 4*100
    syncPhase();
    for (int n = 0; n < 3; n++) applyStimulus(12'sd658, -12'sd638, 4'b1101, 1'b1, 1'b0);
    checkOutput("evm_no_early_pulse", evm_pulses, 0);
    applyStimulus(12'sd658, -12'sd638, 4'b1101, 1'b1, 1'b0);
    checkOutput("evm_pulses_w1", evm_pulses, 1);
    checkOutput("evm_acc_w1", last_acc, 80);
    checkOutput("evm_valid_low", {31'd0, evm_valid}, 0);
    for (int n = 0; n < 4; n++) applyStimulus(12'sd2000, -12'sd1900, 4'b1000, 1'b1, 1'b0);
    checkOutput("evm_pulses_w2", evm_pulses, 2);
    checkOutput("evm_acc_w2", last_acc, 400);
    checkOutput("evm_acc_hold", {16'd0, evm_acc}, 400);
    idle(3);

    // Phase selection and one-cycle latency
    syncPhase();
    pops_before = pop_count;
    s_valid = 1'b1; s_i = '0; s_q = '0;
    step();
    step();
    s_i = 12'sd1943; s_q = -12'sd648;
    exp_q.push_back(4'b1001);
    checkOutput("t1_mvalid_before", {31'd0, m_valid}, 0);
    step();
    checkOutput("t1_mvalid_after", {31'd0, m_valid}, 1);
    s_i = '0; s_q = '0;
    step();
    for (int n = 0; n < 2; n++) applyStimulus(12'sd1943, -12'sd648, 4'b1001, 1'b1, 1'b0);
    idle(3);
    checkOutput("t1_pop_count", pop_count - pops_before, 3);

    // Threshold table
    syncPhase();
    for (int v = 0; v < 9; v++) applyStimulus(vecs[v].i, vecs[v].q, vecs[v].bits, 1'b1, 1'b0);
    idle(3);
    checkOutput("t2_queue_drained", exp_q.size(), 0);

    // Overflow: third symbol dropped, contents kept
    syncPhase();
    m_ready = 1'b0;
    pops_before = pop_count;
    applyStimulus(12'sd1943, 12'sd1943, 4'b1010, 1'b1, 1'b0);
    applyStimulus(-12'sd1943, -12'sd648, 4'b0001, 1'b1, 1'b0);
    applyStimulus(-12'sd648, 12'sd1943, 4'b0110, 1'b0, 1'b0);
    idle(1);
    checkOutput("t3_overflow_set", {31'd0, overflow}, 1);
    checkOutput("t3_head_kept", {28'd0, m_bits}, 4'b1010);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    checkOutput("t3_overflow_clr", {31'd0, overflow}, 0);
    m_ready = 1'b1;
    idle(4);
    checkOutput("t3_pops", pop_count - pops_before, 2);
    checkOutput("t3_empty", {31'd0, m_valid}, 0);

    // Full FIFO with a pop on the decision cycle: no drop, order kept
    syncPhase();
    m_ready = 1'b0;
    pops_before = pop_count;
    applyStimulus(12'sd648, -12'sd1943, 4'b1100, 1'b1, 1'b0);
    applyStimulus(-12'sd1943, 12'sd1943, 4'b0010, 1'b1, 1'b0);
    applyStimulus(12'sd1943, 12'sd648, 4'b1011, 1'b1, 1'b1);
    idle(4);
    checkOutput("t4_no_overflow", {31'd0, overflow}, 0);
    checkOutput("t4_pops", pop_count - pops_before, 3);

    // Reset while full, overflowed and mid-window
    syncPhase();
    m_ready = 1'b0;
    applyStimulus(12'sd648, 12'sd648, 4'b1111, 1'b1, 1'b0);
    applyStimulus(12'sd648, 12'sd648, 4'b1111, 1'b1, 1'b0);
    applyStimulus(12'sd648, 12'sd648, 4'b1111, 1'b0, 1'b0);
    s_valid = 1'b1; s_i = '0; s_q = '0;
    step();
    step();
    checkOutput("t6_pre_overflow", {31'd0, overflow}, 1);
    s_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_m_valid", {31'd0, m_valid}, 0);
    checkOutput("t6_rst_evm_acc", {16'd0, evm_acc}, 0);
    checkOutput("t6_rst_overflow", {31'd0, overflow}, 0);
    checkOutput("t6_rst_m_bits", {28'd0, m_bits}, 0);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    m_ready = 1'b1;
    pops_before = pop_count;
    s_valid = 1'b1; s_i = '0; s_q = '0;
    step();
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    for (int n = 0; n < 2; n++) applyStimulus(-12'sd648, 12'sd648, 4'b0111, 1'b1, 1'b0);
    idle(4);
    checkOutput("t6_pops", pop_count - pops_before, 2);
    checkOutput("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qam16_demapper.md
Name: qam16_demapper

Overview:
Receive-side counterpart of the 16-QAM mapper. It takes the matched-filtered I/Q sample stream at SPS samples per symbol and decimates to one sample per symbol at a selectable phase. Each selected sample is hard-sliced to the nearest normalised constellation point and Gray-decoded to 4 bits. The bits are buffered in a 2-entry output FIFO with valid/ready handshake, and a windowed L1 error-magnitude sum is accumulated as an EVM proxy. It sits between the RX RRC filter and the PRBS-23 BER checker.

Parameters:
SPS, 4, samples per symbol; must be a power of 2.
EVM_LOG2, 8, log2 of symbols per EVM window.
FIFO_DEPTH, 2, output FIFO entries; fixed at 2.

Ports:
clk  in  1  system clock, 27 MHz domain
rst_n  in  1  asynchronous active-low reset
sync_clr  in  1  synchronous clear of the phase counter
phase_sel  in  $clog2(SPS)  sample index within a symbol that is sliced
s_valid  in  1  input sample strobe; no backpressure upstream
s_i  in  DATA_WIDTH  I sample, signed Q1.11 (sample_t)
s_q  in  DATA_WIDTH  Q sample, signed Q1.11
m_valid  out  1  output symbol available
m_ready  in  1  consumer accepts symbol
m_bits  out  4  decoded bits; [3:2] from I, [1:0] from Q
overflow  out  1  sticky: symbol dropped because FIFO was full
ovf_clr  in  1  synchronous clear of overflow
evm_acc  out  14+EVM_LOG2  last completed window error sum, unsigned
evm_valid  out  1  one-cycle pulse when evm_acc updates

Behaviour:
- Reset (rst_n=0, async): phase counter=0, FIFO empty, m_valid=0, m_bits=0, overflow=0, evm_acc=0, evm_valid=0, window counter=0, running sum=0.
- Phase counter: increments mod SPS on each s_valid. sync_clr forces it to 0 and takes priority over increment.
- Decision event: s_valid=1 and counter==phase_sel in cycle N. Changing phase_sel mid-stream takes effect immediately and may skip or duplicate one symbol; this is accepted behaviour.
- Slicer, per axis x (signed 12-bit):
  - x>=1296 maps to +3 (1943), Gray code 10.
  - 0<=x<1296 maps to +1 (648), code 11.
  - -1296<x<0 maps to -1 (-648), code 01.
  - x<=-1296 maps to -3 (-1943), code 00.
  - Zero maps to +1.
- Output FIFO:
  - The decision is written on the clock edge ending cycle N. m_valid is asserted from cycle N+1 (latency 1).
  - A pop occurs when m_valid&&m_ready. m_bits always shows the head entry.
  - Simultaneous push and pop when full: the pop happens first and the push is accepted; no overflow.
  - Push when full with no pop: the new symbol is dropped, overflow is set, and FIFO contents are unchanged.
  - If ovf_clr and a new overflow occur in the same cycle, the set wins.
- Error calculation:
  - Per decision: e = |x - ideal_i| + |y - ideal_q|, where each difference is 13-bit signed and the sum is 14-bit unsigned.
  - e is accumulated into the running sum on the same edge as the FIFO write.
  - It is computed even when the symbol is dropped on overflow.
- EVM window:
  - After 2^EVM_LOG2 decisions, evm_acc is loaded with running sum + e, and evm_valid pulses in cycle N+1.
  - On the same edge the running sum restarts at 0 and the window counter wraps.
  - The running sum cannot overflow: its width is 14+EVM_LOG2.
- No other state; mid-operation reset returns all state to reset values immediately.

Decomposition:
- gdsp_pkg gains:
  - QAM_THR = 12'sd1296 (decision threshold).
  - Gray code constants GRAY_NEG3=2'b00, GRAY_NEG1=2'b01, GRAY_POS1=2'b11, GRAY_POS3=2'b10, shared with the mapper.
  - typedef logic [3:0] qam_bits_t.
- One sub-module, qam16_slicer_axis: combinational, maps a sample_t to a 2-bit Gray code, the ideal level, and the 13-bit absolute error. It is instantiated twice, for I and Q.

Test Plan:
1. SPS=4, phase_sel=2, continuous s_valid, sample index 2 = (I=1943, Q=-648), other indices = (0, 0) -> exactly one m_bits=4'b1001 per 4 samples, first m_valid the cycle after index 2.
2. Threshold sweep on I with Q=0:
   - I=1295 -> bits[3:2]=11; I=1296 -> 10.
   - I=-1295 -> 01; I=-1296 -> 00.
   - I=0 -> 11; Q=0 gives bits[1:0]=11.
3. m_ready=0 with 3 decisions -> first two symbols held in order and overflow=1. Then m_ready=1 -> exactly 2 pops, and the third symbol never appears. ovf_clr -> overflow=0.
4. FIFO full with m_ready=1 on the cycle a new decision arrives -> no overflow, and the output order is preserved.
5. EVM_LOG2=2, four decisions of (I=658, Q=-638) -> e=20 each, then evm_valid pulses once with evm_acc=80. The next window starts from 0.
6. Assert rst_n=0 while the FIFO is non-empty and mid-window -> m_valid=0, evm_acc=0, overflow=0 immediately. After release with sync_clr pulsed, decisions resume at the correct phase.
